ysyx_24100029_arbiter: RTL and testbench

YSYX_24100029_ARBITER -- requirements
Module: ysyx_24100029_arbiter

---
 rtl/ysyx_24100029_arbiter_if.sv | 63 ++++++
 rtl/ysyx_24100029_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ysyx_24100029_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24100029_arbiter_if.sv
// AXI4 bundle shared by the IFU/LSU ports and the downstream port.
// master drives requests; slave drives ready and responses.
interface ysyx_24100029_arbiter_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        rlast;
  logic [3:0]  rid;

  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        wlast;

  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  bid;

  modport master (
    output araddr, arvalid, arid, arlen, arsize, arburst,
    input  arready,
    input  rdata, rresp, rvalid, rlast, rid,
    output rready,
    output awaddr, awvalid, awid, awlen, awsize, awburst,
    input  awready,
    output wdata, wstrb, wvalid, wlast,
    input  wready,
    input  bresp, bvalid, bid,
    output bready
  );

  modport slave (
    input  araddr, arvalid, arid, arlen, arsize, arburst,
    output arready,
    output rdata, rresp, rvalid, rlast, rid,
    input  rready,
    input  awaddr, awvalid, awid, awlen, awsize, awburst,
    output awready,
    input  wdata, wstrb, wvalid, wlast,
    output wready,
    output bresp, bvalid, bid,
    input  bready
  );
endinterface

// File: rtl/ysyx_24100029_arbiter.sv
// Two-master AXI4 arbiter: IFU (m0, read) and LSU (m1, read/write)
// share one downstream slave; round-robin, one grant at a time.
module ysyx_24100029_arbiter (
  input logic clock,
  input logic reset,
  ysyx_24100029_arbiter_if.slave  m0,
  ysyx_24100029_arbiter_if.slave  m1,
  ysyx_24100029_arbiter_if.master s
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    M0_RD = 2'd1,
    M1_RD = 2'd2,
    M1_WR = 2'd3
  } state_e;

  state_e state_q, state_d;
  // 0: m0 was granted last, 1: m1 was granted last
  logic   last_grant_q, last_grant_d;
  logic   m1_req;

  assign m1_req = m1.awvalid | m1.arvalid;

  // State and round-robin pointer; reset lets m0 win the first tie
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Grant selection in IDLE, release on last beat or write response
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (m0.arvalid && (!m1_req || last_grant_q)) begin
          state_d      = M0_RD;
          last_grant_d = 1'b0;
        end else if (m1.awvalid) begin
          state_d      = M1_WR;
          last_grant_d = 1'b1;
        end else if (m1.arvalid) begin
          state_d      = M1_RD;
          last_grant_d = 1'b1;
        end
      end
      M0_RD: begin
        if (s.rvalid && m0.rready && s.rlast)
          state_d = IDLE;
      end
      M1_RD: begin
        if (s.rvalid && m1.rready && s.rlast)
          state_d = IDLE;
      end
      M1_WR: begin
        if (s.bvalid && m1.bready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Channel routing for the granted master; everyone else is held off
  always_comb begin
    s.araddr   = 32'h0;
    s.arvalid  = 1'b0;
    s.arid     = 4'h0;
    s.arlen    = 8'h0;
    s.arsize   = 3'h0;
    s.arburst  = 2'h0;
    s.rready   = 1'b0;
    s.awaddr   = 32'h0;
    s.awvalid  = 1'b0;
    s.awid     = 4'h0;
    s.awlen    = 8'h0;
    s.awsize   = 3'h0;
    s.awburst  = 2'h0;
    s.wdata    = 32'h0;
    s.wstrb    = 4'h0;
    s.wvalid   = 1'b0;
    s.wlast    = 1'b0;
    s.bready   = 1'b0;

    m0.arready = 1'b0;
    m0.rdata   = 32'h0;
    m0.rresp   = 2'h0;
    m0.rvalid  = 1'b0;
    m0.rlast   = 1'b0;
    m0.rid     = 4'h0;
    m0.awready = 1'b0;
    m0.wready  = 1'b0;
    m0.bresp   = 2'h0;
    m0.bvalid  = 1'b0;
    m0.bid     = 4'h0;

    m1.arready = 1'b0;
    m1.rdata   = 32'h0;
    m1.rresp   = 2'h0;
    m1.rvalid  = 1'b0;
    m1.rlast   = 1'b0;
    m1.rid     = 4'h0;
    m1.awready = 1'b0;
    m1.wready  = 1'b0;
    m1.bresp   = 2'h0;
    m1.bvalid  = 1'b0;
    m1.bid     = 4'h0;

    unique case (state_q)
      M0_RD: begin
        s.araddr   = m0.araddr;
        s.arvalid  = m0.arvalid;
        s.arid     = m0.arid;
        s.arlen    = m0.arlen;
        s.arsize   = m0.arsize;
        s.arburst  = m0.arburst;
        s.rready   = m0.rready;
        m0.arready = s.arready;
        m0.rdata   = s.rdata;
        m0.rresp   = s.rresp;
        m0.rvalid  = s.rvalid;
        m0.rlast   = s.rlast;
        m0.rid     = s.rid;
      end
      M1_RD: begin
        s.araddr   = m1.araddr;
        s.arvalid  = m1.arvalid;
        s.arid     = m1.arid;
        s.arlen    = m1.arlen;
        s.arsize   = m1.arsize;
        s.arburst  = m1.arburst;
        s.rready   = m1.rready;
        m1.arready = s.arready;
        m1.rdata   = s.rdata;
        m1.rresp   = s.rresp;
        m1.rvalid  = s.rvalid;
        m1.rlast   = s.rlast;
        m1.rid     = s.rid;
      end
      M1_WR: begin
        s.awaddr   = m1.awaddr;
        s.awvalid  = m1.awvalid;
        s.awid     = m1.awid;
        s.awlen    = m1.awlen;
        s.awsize   = m1.awsize;
        s.awburst  = m1.awburst;
        s.wdata    = m1.wdata;
        s.wstrb    = m1.wstrb;
        s.wvalid   = m1.wvalid;
        s.wlast    = m1.wlast;
        s.bready   = m1.bready;
        m1.awready = s.awready;
        m1.wready  = s.wready;
        m1.bresp   = s.bresp;
        m1.bvalid  = s.bvalid;
        m1.bid     = s.bid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_24100029_arbiter.sv
// Directed-vector bench for the two-master AXI4 arbiter.
// Inputs change 1ns after the rising edge; checks follow 1ns later.
module tb_ysyx_24100029_arbiter;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;
  int   beats;

  ysyx_24100029_arbiter_if m0_if ();
  ysyx_24100029_arbiter_if m1_if ();
  ysyx_24100029_arbiter_if s_if ();

  ysyx_24100029_arbiter dut (
    .clock (clock),
    .reset (reset),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic init_inputs();
    m0_if.araddr = 0; m0_if.arvalid = 0; m0_if.arid = 0;
    m0_if.arlen = 0; m0_if.arsize = 3'd2; m0_if.arburst = 2'd1;
    m0_if.rready = 0;
    m0_if.awaddr = 0; m0_if.awvalid = 0; m0_if.awid = 0;
    m0_if.awlen = 0; m0_if.awsize = 0; m0_if.awburst = 0;
    m0_if.wdata = 0; m0_if.wstrb = 0; m0_if.wvalid = 0;
    m0_if.wlast = 0; m0_if.bready = 0;
    m1_if.araddr = 0; m1_if.arvalid = 0; m1_if.arid = 0;
    m1_if.arlen = 0; m1_if.arsize = 3'd2; m1_if.arburst = 2'd1;
    m1_if.rready = 0;
    m1_if.awaddr = 0; m1_if.awvalid = 0; m1_if.awid = 0;
    m1_if.awlen = 0; m1_if.awsize = 3'd2; m1_if.awburst = 2'd1;
    m1_if.wdata = 0; m1_if.wstrb = 0; m1_if.wvalid = 0;
    m1_if.wlast = 0; m1_if.bready = 0;
    s_if.arready = 1; s_if.awready = 1; s_if.wready = 1;
    s_if.rdata = 0; s_if.rresp = 0; s_if.rvalid = 0;
    s_if.rlast = 0; s_if.rid = 0;
    s_if.bresp = 0; s_if.bvalid = 0; s_if.bid = 0;
  endtask

  task automatic rsp(input logic [31:0] d, input logic [3:0] id,
                     input logic last);
    s_if.rvalid = 1; s_if.rdata = d; s_if.rid = id;
    s_if.rlast = last; s_if.rresp = 2'd0;
  endtask

  task automatic rsp_off();
    s_if.rvalid = 0; s_if.rlast = 0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    init_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
    settle();

    // reset state: everything idle
    chk("rst_s_arvalid", {31'd0, s_if.arvalid}, 0);
    chk("rst_s_rready", {31'd0, s_if.rready}, 0);
    chk("rst_m0_arready", {31'd0, m0_if.arready}, 0);
    chk("rst_m1_bvalid", {31'd0, m1_if.bvalid}, 0);
    chk("rst_s_awvalid", {31'd0, s_if.awvalid}, 0);

    // single read from m0
    m0_if.arvalid = 1; m0_if.araddr = 32'h0200_0000;
    m0_if.arid = 4'd3; m0_if.rready = 1;
    settle();
    chk("rd_latency", {31'd0, s_if.arvalid}, 0);
    tick();
    chk("rd_s_arvalid", {31'd0, s_if.arvalid}, 1);
    chk("rd_s_araddr", s_if.araddr, 32'h0200_0000);
    chk("rd_s_arid", {28'd0, s_if.arid}, 3);
    chk("rd_m0_arready", {31'd0, m0_if.arready}, 1);
    tick();
    m0_if.arvalid = 0;
    rsp(32'h1234, 4'd3, 1);
    settle();
    chk("rd_m0_rvalid", {31'd0, m0_if.rvalid}, 1);
    chk("rd_m0_rdata", m0_if.rdata, 32'h1234);
    chk("rd_m0_rid", {28'd0, m0_if.rid}, 3);
    chk("rd_s_rready", {31'd0, s_if.rready}, 1);
    tick();
    rsp_off();
    settle();
    chk("rd_idle_rvalid", {31'd0, m0_if.rvalid}, 0);
    chk("rd_idle_arready", {31'd0, m0_if.arready}, 0);

    // tie right after reset: m0, then m1, then m0 again
    reset = 1;
    tick();
    reset = 0;
    m0_if.arvalid = 1; m0_if.araddr = 32'h0000_00A0;
    m1_if.arvalid = 1; m1_if.araddr = 32'h0000_00A1;
    m1_if.rready = 1;
    tick();
    chk("tie1_addr", s_if.araddr, 32'h0000_00A0);
    chk("tie1_m1_stall", {31'd0, m1_if.arready}, 0);
    tick();
    m0_if.arvalid = 0;
    rsp(32'h11, 4'd0, 1);
    tick();
    rsp_off();
    settle();
    chk("tie1_gap_arvalid", {31'd0, s_if.arvalid}, 0);
    chk("tie1_gap_m1_arready", {31'd0, m1_if.arready}, 0);
    tick();
    chk("tie1_m1_addr", s_if.araddr, 32'h0000_00A1);
    chk("tie1_m1_arready", {31'd0, m1_if.arready}, 1);
    tick();
    m1_if.arvalid = 0;
    rsp(32'h22, 4'd0, 1);
    settle();
    chk("tie1_m1_rdata", m1_if.rdata, 32'h22);
    chk("tie1_m0_rvalid", {31'd0, m0_if.rvalid}, 0);
    tick();
    rsp_off();
    m0_if.arvalid = 1;
    m1_if.arvalid = 1;
    tick();
    chk("tie2_addr", s_if.araddr, 32'h0000_00A0);
    chk("tie2_m0_arready", {31'd0, m0_if.arready}, 1);
    tick();
    m0_if.arvalid = 0;
    m1_if.arvalid = 0;
    rsp(32'h33, 4'd0, 1);
    tick();
    rsp_off();
    tick();

    // write from m1, W handshake before AW
    m1_if.awvalid = 1; m1_if.awaddr = 32'h8000_0000;
    m1_if.awid = 4'd5;
    m1_if.wvalid = 1; m1_if.wdata = 32'hDEAD_BEEF;
    m1_if.wstrb = 4'hF; m1_if.wlast = 1;
    s_if.awready = 0;
    tick();
    chk("wr_s_wvalid", {31'd0, s_if.wvalid}, 1);
    chk("wr_s_wdata", s_if.wdata, 32'hDEAD_BEEF);
    chk("wr_s_wstrb", {28'd0, s_if.wstrb}, 32'hF);
    chk("wr_m1_wready", {31'd0, m1_if.wready}, 1);
    chk("wr_m1_awready0", {31'd0, m1_if.awready}, 0);
    chk("wr_s_awaddr", s_if.awaddr, 32'h8000_0000);
    tick();
    m1_if.wvalid = 0;
    s_if.awready = 1;
    settle();
    chk("wr_m1_awready1", {31'd0, m1_if.awready}, 1);
    tick();
    m1_if.awvalid = 0;
    s_if.bvalid = 1; s_if.bid = 4'd5; s_if.bresp = 2'd0;
    settle();
    chk("wr_m1_bvalid", {31'd0, m1_if.bvalid}, 1);
    chk("wr_m1_bid", {28'd0, m1_if.bid}, 5);
    chk("wr_s_bready0", {31'd0, s_if.bready}, 0);
    tick();
    m1_if.bready = 1;
    settle();
    chk("wr_hold_bvalid", {31'd0, m1_if.bvalid}, 1);
    chk("wr_s_bready1", {31'd0, s_if.bready}, 1);
    tick();
    s_if.bvalid = 0;
    settle();
    chk("wr_idle_bvalid", {31'd0, m1_if.bvalid}, 0);
    chk("wr_idle_bready", {31'd0, s_if.bready}, 0);

    // 4-beat burst on m1, m0 stalled until last beat
    m1_if.arvalid = 1; m1_if.araddr = 32'h0000_1000;
    m1_if.arlen = 8'd3; m1_if.arid = 4'd7;
    tick();
    chk("bst_arlen", {24'd0, s_if.arlen}, 3);
    tick();
    m1_if.arvalid = 0;
    m0_if.arvalid = 1; m0_if.araddr = 32'h0000_2000;
    beats = 0;
    for (int i = 0; i < 4; i++) begin
      rsp(32'hB0 + i, 4'd7, i == 3);
      settle();
      if (m1_if.rvalid && s_if.rready) beats++;
      chk("bst_m0_stall", {31'd0, m0_if.arready}, 0);
      chk("bst_rdata", m1_if.rdata, 32'hB0 + i);
      tick();
    end
    rsp_off();
    settle();
    chk("bst_beats", beats, 4);
    chk("bst_gap_m0_arready", {31'd0, m0_if.arready}, 0);
    tick();
    chk("bst_m0_granted", {31'd0, m0_if.arready}, 1);
    chk("bst_m0_addr", s_if.araddr, 32'h0000_2000);
    tick();
    m0_if.arvalid = 0;
    rsp(32'h44, 4'd0, 1);
    tick();
    rsp_off();
    tick();

    // m1 read and write together: write first
    m1_if.arlen = 0;
    m1_if.arvalid = 1; m1_if.araddr = 32'h0000_3000;
    m1_if.awvalid = 1; m1_if.awaddr = 32'h0000_4000;
    m1_if.wvalid = 1; m1_if.wdata = 32'h5;
    tick();
    chk("rw_s_awvalid", {31'd0, s_if.awvalid}, 1);
    chk("rw_s_arvalid", {31'd0, s_if.arvalid}, 0);
    chk("rw_s_awaddr", s_if.awaddr, 32'h0000_4000);
    tick();
    m1_if.awvalid = 0;
    m1_if.wvalid = 0;
    s_if.bvalid = 1;
    tick();
    s_if.bvalid = 0;
    settle();
    chk("rw_gap_arvalid", {31'd0, s_if.arvalid}, 0);
    tick();
    chk("rw_rd_arvalid", {31'd0, s_if.arvalid}, 1);
    chk("rw_rd_araddr", s_if.araddr, 32'h0000_3000);
    tick();
    m1_if.arvalid = 0;
    rsp(32'h55, 4'd0, 1);
    tick();
    rsp_off();
    tick();

    // withdrawn request keeps grant; reset mid-read abandons it
    m0_if.arvalid = 1; m0_if.araddr = 32'h0000_00A0;
    s_if.arready = 0;
    tick();
    m0_if.arvalid = 0;
    m1_if.arvalid = 1;
    tick();
    s_if.arready = 1;
    settle();
    chk("wd_m0_still_granted", {31'd0, m0_if.arready}, 1);
    chk("wd_m1_stall", {31'd0, m1_if.arready}, 0);
    rsp(32'h66, 4'd0, 0);
    settle();
    chk("wd_m0_rvalid", {31'd0, m0_if.rvalid}, 1);
    reset = 1;
    s_if.rlast = 1;
    tick();
    chk("mr_m0_rvalid", {31'd0, m0_if.rvalid}, 0);
    chk("mr_s_rready", {31'd0, s_if.rready}, 0);
    chk("mr_s_arvalid", {31'd0, s_if.arvalid}, 0);
    chk("mr_m0_arready", {31'd0, m0_if.arready}, 0);
    rsp_off();
    reset = 0;
    m0_if.arvalid = 1;
    tick();
    chk("mr_tie_m0", {31'd0, m0_if.arready}, 1);
    chk("mr_tie_m1", {31'd0, m1_if.arready}, 0);
    chk("mr_tie_addr", s_if.araddr, 32'h0000_00A0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
